// File: rtl/ofdm_rx_frame_ctrl.sv
// Frame-level sequencer for the OFDM RX chain: datapath init, frame search,
// symbol/bit tracking, frame completion and stall timeout detection.
module ofdm_rx_frame_ctrl #(
    parameter int raw_symbol_length_g = 160,
    parameter int symbols_per_frame_g = 12,
    parameter int search_timeout_g    = 100000,
    parameter int rcv_timeout_g       = 2000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       sys_init,
    input  logic       rx_data_valid,
    input  logic       coarse_found,
    input  logic       rx_symbols_start,
    input  logic       rx_rcv_data_valid,
    output logic       chain_init,
    output logic       search_en,
    output logic       rcv_en,
    output logic [7:0] symbol_cnt,
    output logic       frame_done,
    output logic       align_err,
    output logic       timeout_err,
    output logic       busy
);

    localparam int tmo_max_c = (search_timeout_g > rcv_timeout_g) ? search_timeout_g : rcv_timeout_g;
    localparam int tmo_w_c   = $clog2(tmo_max_c + 1);
    localparam int bit_w_c   = $clog2(raw_symbol_length_g);

    localparam logic [tmo_w_c-1:0] search_last_c = tmo_w_c'(search_timeout_g - 1);
    localparam logic [tmo_w_c-1:0] rcv_last_c    = tmo_w_c'(rcv_timeout_g - 1);
    localparam logic [bit_w_c-1:0] bit_last_c    = bit_w_c'(raw_symbol_length_g - 2);
    localparam logic [bit_w_c-1:0] bit_step_c    = bit_w_c'(2);
    localparam logic [7:0]         sym_last_c    = 8'(symbols_per_frame_g - 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SEARCH,
        WAIT_SYM,
        RECEIVE,
        DONE,
        FAIL
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [bit_w_c-1:0] bit_cnt;
    logic [bit_w_c-1:0] bit_cnt_next;
    logic [tmo_w_c-1:0] tmo_cnt;
    logic [tmo_w_c-1:0] tmo_cnt_next;
    logic [7:0]         symbol_cnt_next;
    logic               align_err_next;
    logic               timeout_err_next;
    logic               chain_init_next;
    logic               search_en_next;
    logic               rcv_en_next;
    logic               frame_done_next;
    logic               busy_next;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
            symbol_cnt  <= '0;
            align_err   <= 1'b0;
            timeout_err <= 1'b0;
            chain_init  <= 1'b0;
            search_en   <= 1'b0;
            rcv_en      <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= next_state;
            bit_cnt     <= bit_cnt_next;
            tmo_cnt     <= tmo_cnt_next;
            symbol_cnt  <= symbol_cnt_next;
            align_err   <= align_err_next;
            timeout_err <= timeout_err_next;
            chain_init  <= chain_init_next;
            search_en   <= search_en_next;
            rcv_en      <= rcv_en_next;
            frame_done  <= frame_done_next;
            busy        <= busy_next;
        end
    end

    // A symbol wrap takes precedence over a misaligned symbol start, and a
    // received bit always rescues the cycle in which the stall limit is hit.
    always_comb begin
        next_state       = state;
        bit_cnt_next     = bit_cnt;
        tmo_cnt_next     = tmo_cnt;
        symbol_cnt_next  = symbol_cnt;
        align_err_next   = 1'b0;
        timeout_err_next = timeout_err;
        if (sys_init) begin
            next_state       = INIT;
            bit_cnt_next     = '0;
            tmo_cnt_next     = '0;
            symbol_cnt_next  = '0;
            timeout_err_next = 1'b0;
        end else begin
            case (state)
                INIT: next_state = SEARCH;
                SEARCH: begin
                    if (coarse_found) begin
                        next_state   = WAIT_SYM;
                        tmo_cnt_next = '0;
                    end else if (rx_data_valid) begin
                        tmo_cnt_next = tmo_cnt + 1'b1;
                        if (tmo_cnt == search_last_c) next_state = FAIL;
                    end
                end
                WAIT_SYM: begin
                    if (rx_symbols_start) begin
                        next_state   = RECEIVE;
                        bit_cnt_next = '0;
                        tmo_cnt_next = '0;
                    end else if (rx_data_valid) begin
                        tmo_cnt_next = tmo_cnt + 1'b1;
                        if (tmo_cnt == search_last_c) next_state = FAIL;
                    end
                end
                RECEIVE: begin
                    if (rx_rcv_data_valid) begin
                        tmo_cnt_next = '0;
                    end else if (rx_data_valid) begin
                        tmo_cnt_next = tmo_cnt + 1'b1;
                        if (tmo_cnt == rcv_last_c) next_state = FAIL;
                    end
                    if (rx_rcv_data_valid && (bit_cnt == bit_last_c)) begin
                        bit_cnt_next    = '0;
                        symbol_cnt_next = symbol_cnt + 8'd1;
                        if (symbol_cnt == sym_last_c) next_state = DONE;
                    end else if (rx_symbols_start && (bit_cnt != '0)) begin
                        align_err_next = 1'b1;
                        bit_cnt_next   = '0;
                    end else if (rx_rcv_data_valid) begin
                        bit_cnt_next = bit_cnt + bit_step_c;
                    end
                end
                DONE, FAIL: next_state = IDLE;
                default: ;
            endcase
            if (next_state == FAIL) timeout_err_next = 1'b1;
        end
    end

    always_comb begin
        chain_init_next = (next_state == INIT);
        search_en_next  = (next_state == SEARCH);
        rcv_en_next     = (next_state == RECEIVE);
        frame_done_next = (next_state == DONE);
        busy_next       = (next_state != IDLE);
    end

endmodule

// File: doc/ofdm_rx_frame_ctrl.md
Name: ofdm_rx_frame_ctrl

Overview:
- Frame-level sequencer for the OFDM RX chain. Sits between the top-level system control and the RX datapath (coarse alignment, fine alignment/FFT, demapper).
- Issues the datapath init pulse, enables frame search, and tracks received OFDM symbols and output bits.
- Declares a frame complete after a configured number of symbols, or flags a timeout when the chain stalls.

Parameters:
- raw_symbol_length_g, 160, output bits per OFDM symbol (even, ≥2).
- symbols_per_frame_g, 12, symbols per frame (1..255).
- search_timeout_g, 100000, input samples allowed in SEARCH/WAIT_SYM before timeout.
- rcv_timeout_g, 2000, input samples allowed without an output bit in RECEIVE before timeout.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous, active-high reset.
- sys_init  in  1  start/restart request (single-cycle pulse).
- rx_data_valid  in  1  input sample strobe (timeout time base).
- coarse_found  in  1  pulse from coarse alignment: frame start detected.
- rx_symbols_start  in  1  pulse: first modulation symbol of an OFDM symbol.
- rx_rcv_data_valid  in  1  strobe: 2 output bits valid.
- chain_init  out  1  one-cycle init pulse to the RX datapath.
- search_en  out  1  enables coarse alignment search.
- rcv_en  out  1  enables demapper output.
- symbol_cnt  out  8  completed symbols in the current frame.
- frame_done  out  1  one-cycle pulse when the frame is complete.
- align_err  out  1  one-cycle pulse on symbol-boundary mismatch.
- timeout_err  out  1  sticky timeout flag.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; internal bit_cnt and tmo_cnt 0.
- States: IDLE, INIT, SEARCH, WAIT_SYM, RECEIVE, DONE, FAIL.
- sys_init has the highest priority. In any state it moves to INIT on the next edge and clears symbol_cnt, bit_cnt, tmo_cnt and timeout_err.
- INIT: chain_init=1 for exactly this one cycle, then SEARCH.
- SEARCH: search_en=1.
  - tmo_cnt increments on each rx_data_valid.
  - coarse_found → WAIT_SYM, tmo_cnt cleared.
  - tmo_cnt reaching search_timeout_g → FAIL.
  - coarse_found wins if it coincides with the terminal count.
- WAIT_SYM: search_en=0.
  - rx_symbols_start → RECEIVE, rcv_en=1 from the next cycle, bit_cnt=0.
  - tmo_cnt counts as in SEARCH, with the same timeout → FAIL.
- RECEIVE: rcv_en=1.
  - Each rx_rcv_data_valid: bit_cnt += 2 and tmo_cnt cleared.
  - When bit_cnt+2 == raw_symbol_length_g: bit_cnt wraps to 0 and symbol_cnt increments in the same cycle.
  - When that increment makes symbol_cnt == symbols_per_frame_g → DONE.
  - rx_symbols_start while bit_cnt != 0 (and not the wrapping cycle): align_err pulses for one cycle and bit_cnt is resynced to 0. symbol_cnt is unchanged.
  - tmo_cnt increments on rx_data_valid. Reaching rcv_timeout_g → FAIL.
  - If a valid bit and the timeout coincide, the bit wins.
- DONE: frame_done=1 for one cycle, rcv_en=0, symbol_cnt held, then IDLE.
- FAIL: timeout_err set (sticky until sys_init or reset); all enables 0; then IDLE.
- IDLE: outputs held except pulses. rx_rcv_data_valid and rx_symbols_start are ignored.
- Strobes in states that don't use them are ignored.
- Counter widths: tmo_cnt is wide enough for max(search_timeout_g, rcv_timeout_g) with no wrap. bit_cnt width is clog2(raw_symbol_length_g).
- Latency: every state change is registered, one cycle after the causing input. Outputs are registered.
- Reset asserted mid-frame: immediate return to reset values. No pulse is emitted on release.

Test Plan:
- Reset, then sys_init, then coarse_found after 500 samples, then rx_symbols_start, then 960 rx_rcv_data_valid (12×80) → chain_init one pulse; symbol_cnt steps 1..12; frame_done one pulse 1 cycle after the 960th strobe; timeout_err=0.
- sys_init, then no coarse_found for 100000 rx_data_valid → FAIL, timeout_err=1, busy=0. A new sys_init clears timeout_err and pulses chain_init.
- In RECEIVE after 40 valid strobes (bit_cnt=80), pulse rx_symbols_start → align_err one pulse, bit_cnt=0, symbol_cnt unchanged. The frame still completes after 960 further strobes.
- In RECEIVE, stop output strobes for 2000 samples → timeout_err=1, rcv_en=0, symbol_cnt held.
- coarse_found coincident with the 100000th sample → WAIT_SYM, no timeout. sys_init pulsed mid-RECEIVE → INIT next cycle, symbol_cnt=0.
- Assert sys_rst during RECEIVE → all outputs 0 asynchronously. Release → IDLE, no frame_done.
